// File: rtl/display_pkg.sv
// Shared display constants and types for the paint scanner
// and the sprite renderers.
package display_pkg;
  localparam int SCREEN_W   = 240;
  localparam int SCREEN_H   = 320;
  localparam int COLOR_W    = 16;
  localparam int LATENCY    = 4;
  localparam int FIFO_DEPTH = 8;
  localparam logic [COLOR_W-1:0] BG_COLOR = 16'h0000;

  typedef logic [COLOR_W-1:0] color_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN
  } scan_state_e;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

  typedef struct packed {
    color_t color;
    logic   first;
    logic   last;
  } pix_t;
endpackage

// File: rtl/paint_scanner_if.sv
// Renderer paint bus plus the outgoing pixel stream.
// master = scanner, slave = renderers/pixel sink.
interface paint_scanner_if;
  import display_pkg::*;

  logic signed [15:0] paint_x;
  logic signed [15:0] paint_y;
  logic   l0_enable;
  logic   l1_enable;
  logic   l2_enable;
  color_t l0_color;
  color_t l1_color;
  color_t l2_color;
  logic   pix_valid;
  logic   pix_ready;
  color_t pix_color;
  logic   pix_first;
  logic   pix_last;

  modport master (
    output paint_x, paint_y,
    input  l0_enable, l1_enable, l2_enable,
    input  l0_color, l1_color, l2_color,
    output pix_valid, pix_color, pix_first, pix_last,
    input  pix_ready
  );

  modport slave (
    input  paint_x, paint_y,
    output l0_enable, l1_enable, l2_enable,
    output l0_color, l1_color, l2_color,
    input  pix_valid, pix_color, pix_first, pix_last,
    output pix_ready
  );
endinterface

// File: rtl/paint_fifo.sv
// Synchronous FIFO with a registered head (output) stage.
// count includes the entry held in the output register.
module paint_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   ready,
  output logic [WIDTH-1:0]       dout,
  output logic                   dvalid,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [AW:0]      ic_q, ic_d;
  logic             ov_q, ov_d;
  logic [WIDTH-1:0] od_q, od_d;
  logic pop, load, from_mem, bypass, wr_mem;

  always_comb begin
    pop      = ov_q & ready;
    load     = !ov_q | pop;
    from_mem = load & (ic_q != '0);
    // empty storage: a push lands straight in the output stage
    bypass   = load & (ic_q == '0) & push;
    wr_mem   = push & !bypass;
    ov_d     = load ? (from_mem | bypass) : 1'b1;
    od_d     = od_q;
    if (from_mem) od_d = mem_q[rp_q];
    else if (bypass) od_d = din;
    wp_d = wr_mem ? wp_q + AW'(1) : wp_q;
    rp_d = from_mem ? rp_q + AW'(1) : rp_q;
    ic_d = ic_q + (AW+1)'(wr_mem) - (AW+1)'(from_mem);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wp_q <= '0;
      rp_q <= '0;
      ic_q <= '0;
      ov_q <= 1'b0;
      od_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      ic_q <= ic_d;
      ov_q <= ov_d;
      od_q <= od_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_mem) mem_q[wp_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      assert (!(push && !pop && count == (AW+1)'(DEPTH)));
    end
  end

  assign count  = ic_q + (AW+1)'(ov_q);
  assign dout   = od_q;
  assign dvalid = ov_q;
endmodule

// File: rtl/paint_scanner.sv
// Raster scanner: issues paint coordinates, merges three layers
// by priority and streams pixels out under FIFO credit control.
module paint_scanner #(
  parameter int SCREEN_W   = display_pkg::SCREEN_W,
  parameter int SCREEN_H   = display_pkg::SCREEN_H,
  parameter int LATENCY    = display_pkg::LATENCY,
  parameter int FIFO_DEPTH = display_pkg::FIFO_DEPTH,
  parameter logic [15:0] BG_COLOR = display_pkg::BG_COLOR
) (
  input  logic clk,
  input  logic rstn,
  input  logic start,
  output logic busy,
  output logic frame_done,
  paint_scanner_if.master bus
);
  import display_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic signed [15:0] X_LAST = 16'(SCREEN_W - 1);
  localparam logic signed [15:0] Y_LAST = 16'(SCREEN_H - 1);

  scan_state_e state_q, state_d;
  logic signed [15:0] x_q, x_d;
  logic signed [15:0] y_q, y_d;
  tag_t tag_q [LATENCY];
  tag_t tag_d [LATENCY];
  tag_t tag_in, tag_out;
  logic seen_q, seen_d;
  logic [CW-1:0] fifo_cnt;
  int   inflight;
  logic issue, at_end, push, pop;
  pix_t push_pix, pop_pix;

  always_comb begin
    inflight = 0;
    for (int i = 0; i < LATENCY; i++)
      inflight = inflight + {31'b0, tag_q[i].valid};
  end

  assign tag_out = tag_q[LATENCY-1];
  assign push    = tag_out.valid;
  assign pop     = bus.pix_valid & bus.pix_ready;

  always_comb begin
    push_pix.first = tag_out.first;
    push_pix.last  = tag_out.last;
    if (bus.l0_enable)      push_pix.color = bus.l0_color;
    else if (bus.l1_enable) push_pix.color = bus.l1_color;
    else if (bus.l2_enable) push_pix.color = bus.l2_color;
    else                    push_pix.color = BG_COLOR;
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    seen_d     = seen_q;
    tag_in     = '0;
    issue      = 1'b0;
    frame_done = 1'b0;
    at_end     = (x_q == X_LAST) && (y_q == Y_LAST);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          x_d     = '0;
          y_d     = '0;
          seen_d  = 1'b0;
        end
      end
      SCAN: begin
        // only issue when every in-flight pixel has a FIFO slot
        issue = (int'(fifo_cnt) + inflight) < FIFO_DEPTH;
        if (issue) begin
          tag_in.valid = 1'b1;
          tag_in.first = (x_q == '0) && (y_q == '0);
          tag_in.last  = at_end;
          if (at_end) begin
            state_d = DRAIN;
          end else if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + 16'sd1;
          end else begin
            x_d = x_q + 16'sd1;
          end
        end
      end
      DRAIN: begin
        if (pop && pop_pix.last) seen_d = 1'b1;
        if (inflight == 0 && fifo_cnt == '0 && seen_q) begin
          frame_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tag_d[0] = tag_in;
    for (int i = 1; i < LATENCY; i++)
      tag_d[i] = tag_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      seen_q  <= 1'b0;
      for (int i = 0; i < LATENCY; i++)
        tag_q[i] <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      seen_q  <= seen_d;
      for (int i = 0; i < LATENCY; i++)
        tag_q[i] <= tag_d[i];
    end
  end

  paint_fifo #(
    .WIDTH($bits(pix_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .din   (push_pix),
    .ready (bus.pix_ready),
    .dout  (pop_pix),
    .dvalid(bus.pix_valid),
    .count (fifo_cnt)
  );

  assign busy          = (state_q != IDLE);
  assign bus.paint_x   = x_q;
  assign bus.paint_y   = y_q;
  assign bus.pix_color = pop_pix.color;
  assign bus.pix_first = pop_pix.first;
  assign bus.pix_last  = pop_pix.last;
endmodule
